alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result buffer: small circular FIFO that recomputes zero, decodes write-back enable and tracks the divider remainder.
// Optional overflow trapping on add/sub is enabled by defining ALU_RESULT_OVF_TRAP_EN.
module alu_result_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_ctrl,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic [WIDTH-1:0] in_r,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_zero,
    output logic             out_wb_en,
    output logic [WIDTH-1:0] hi_reg,
    output logic             ovf_trap
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [WIDTH-1:0] result_mem [DEPTH];
    logic [4:0]       rd_mem     [DEPTH];
    logic             zero_mem   [DEPTH];
    logic             wb_mem     [DEPTH];

    logic push;
    logic pop;
    logic wb_base;
    logic ovf_hit;
    logic wb_store;

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wb_base = 1'b0;
        case (in_alu_ctrl)
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0110, 4'b0111: wb_base = 1'b1;
            default:                   wb_base = 1'b0;
        endcase
    end

`ifdef ALU_RESULT_OVF_TRAP_EN
    assign ovf_hit = in_overflow && ((in_alu_ctrl == 4'b0010) || (in_alu_ctrl == 4'b0110));

    // Pulse lands in the cycle right after the trapping push.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_trap <= 1'b0;
        end else begin
            ovf_trap <= push && ovf_hit;
        end
    end
`else
    logic unused_overflow;
    assign unused_overflow = in_overflow;
    assign ovf_hit         = 1'b0;
    assign ovf_trap        = 1'b0;
`endif

    assign wb_store = wb_base && !ovf_hit;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            result_mem[wr_ptr_reg] <= in_result;
            rd_mem[wr_ptr_reg]     <= in_rd;
            zero_mem[wr_ptr_reg]   <= (in_result == '0);
            wb_mem[wr_ptr_reg]     <= wb_store;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= '0;
        end else if (push && (in_alu_ctrl == 4'b0100)) begin
            hi_reg <= in_r;
        end
    end

    // Head fields are forced to zero whenever nothing is buffered.
    assign out_result = out_valid ? result_mem[rd_ptr_reg] : '0;
    assign out_rd     = out_valid ? rd_mem[rd_ptr_reg]     : '0;
    assign out_zero   = out_valid ? zero_mem[rd_ptr_reg]   : 1'b0;
    assign out_wb_en  = out_valid ? wb_mem[rd_ptr_reg]     : 1'b0;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: hand-computed vectors for buffering, stall, flush, hi_reg, decode and overflow.
module tb_alu_result_stage;
    localparam int WIDTH = 64;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_ctrl;
    logic [WIDTH-1:0] in_result;
    logic             in_overflow;
    logic [WIDTH-1:0] in_r;
    logic [4:0]       in_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_rd;
    logic             out_zero;
    logic             out_wb_en;
    logic [WIDTH-1:0] hi_reg;
    logic             ovf_trap;

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_ctrl(in_alu_ctrl),
        .in_result  (in_result),
        .in_overflow(in_overflow),
        .in_r       (in_r),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .out_wb_en  (out_wb_en),
        .hi_reg     (hi_reg),
        .ovf_trap   (ovf_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ctrl, input logic [63:0] res,
                         input logic [63:0] r, input logic [4:0] rd, input logic ovf);
        in_valid    = v;
        in_alu_ctrl = ctrl;
        in_result   = res;
        in_r        = r;
        in_rd       = rd;
        in_overflow = ovf;
    endtask

    // Advance one edge and settle 1ns past it before sampling.
    task automatic step();
        $display("t=%0t valid=%0b ctrl=%b res=%0d rd=%0d ovf=%0b flush=%0b oready=%0b rst=%0b",
                 $time, in_valid, in_alu_ctrl, in_result, in_rd, in_overflow, flush, out_ready, rst);
        @(posedge clk);
        #1;
    endtask

    logic exp_trap_wb;
    logic exp_trap_pulse;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_hi_reg",    hi_reg,         64'd0);
        check("rst_ovf_trap",  64'(ovf_trap),  64'd0);
        check("rst_out_result", out_result,    64'd0);
        rst = 1'b0;

        // Basic push with one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 64'd5, 64'd0, 5'd3, 1'b0);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("basic_valid",  64'(out_valid), 64'd1);
        check("basic_result", out_result,     64'd5);
        check("basic_rd",     64'(out_rd),    64'd3);
        check("basic_zero",   64'(out_zero),  64'd0);
        check("basic_wb",     64'(out_wb_en), 64'd1);
        step();
        check("basic_popped", 64'(out_valid), 64'd0);
        check("idle_result_zero", out_result, 64'd0);

        // Backpressure: two accepted, third held upstream
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 64'd10, 64'd0, 5'd1, 1'b0);
        step();
        check("bp_ready_1", 64'(in_ready), 64'd1);
        drive(1'b1, 4'b0000, 64'd20, 64'd0, 5'd2, 1'b0);
        step();
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_head_a", out_result, 64'd10);
        drive(1'b1, 4'b0000, 64'd30, 64'd0, 5'd4, 1'b0);
        step();
        check("bp_still_full", 64'(in_ready), 64'd0);
        check("bp_head_stable", out_result, 64'd10);
        check("bp_rd_stable", 64'(out_rd), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_head_b", out_result, 64'd20);
        check("bp_ready_after_pop", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("bp_head_c", out_result, 64'd30);
        check("bp_rd_c", 64'(out_rd), 64'd4);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // hi_reg loads only on ctrl 0100
        drive(1'b1, 4'b0100, 64'd7, 64'd2, 5'd5, 1'b0);
        step();
        check("hi_load", hi_reg, 64'd2);
        check("hi_div_result", out_result, 64'd7);
        drive(1'b1, 4'b0010, 64'd1, 64'd9, 5'd6, 1'b0);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("hi_hold", hi_reg, 64'd2);
        check("hi_next_result", out_result, 64'd1);
        step();

        // Flush with two buffered and a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 4'b0000, 64'd40, 64'd0, 5'd7, 1'b0);
        step();
        drive(1'b1, 4'b0100, 64'd50, 64'd77, 5'd8, 1'b0);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        check("fl_hi_before", hi_reg, 64'd77);
        flush = 1'b1;
        drive(1'b1, 4'b0100, 64'd60, 64'd99, 5'd9, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_hi_unchanged", hi_reg, 64'd77);
        drive(1'b1, 4'b0000, 64'd70, 64'd0, 5'd10, 1'b0);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("fl_after_push", out_result, 64'd70);
        out_ready = 1'b1;
        step();

        // Zero recompute and write-back decode over every ctrl code
        drive(1'b1, 4'b0110, 64'd0, 64'd0, 5'd11, 1'b0);
        step();
        check("zero_flag", 64'(out_zero), 64'd1);
        check("zero_wb", 64'(out_wb_en), 64'd1);
        for (int c = 0; c < 16; c++) begin
            logic [3:0] code;
            logic exp_wb;
            code = 4'(c);
            exp_wb = (c == 0) || (c == 1) || (c == 2) || (c == 4) || (c == 6) || (c == 7);
            drive(1'b1, code, 64'(c + 100), 64'd0, 5'(c), 1'b0);
            step();
            check($sformatf("wb_ctrl_%0d", c), 64'(out_wb_en), 64'(exp_wb));
            check($sformatf("nz_ctrl_%0d", c), 64'(out_zero), 64'd0);
        end
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        step();

        // Overflow on add
`ifdef ALU_RESULT_OVF_TRAP_EN
        exp_trap_wb = 1'b0; exp_trap_pulse = 1'b1;
`else
        exp_trap_wb = 1'b1; exp_trap_pulse = 1'b0;
`endif
        drive(1'b1, 4'b0010, 64'd8, 64'd0, 5'd12, 1'b1);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("ovf_wb", 64'(out_wb_en), 64'(exp_trap_wb));
        check("ovf_trap_pulse", 64'(ovf_trap), 64'(exp_trap_pulse));
        step();
        check("ovf_trap_end", 64'(ovf_trap), 64'd0);
        drive(1'b1, 4'b0000, 64'd9, 64'd0, 5'd13, 1'b1);
        step();
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("ovf_and_wb", 64'(out_wb_en), 64'd1);
        check("ovf_and_no_trap", 64'(ovf_trap), 64'd0);
        step();

        // Reset wins over a concurrent push
        drive(1'b1, 4'b0100, 64'd3, 64'd44, 5'd14, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 4'b0000, 64'd0, 64'd0, 5'd0, 1'b0);
        check("rst_push_lost", 64'(out_valid), 64'd0);
        check("rst_hi_cleared", hi_reg, 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
